// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_pkg
//  Description : Shared backend definitions for the system-instruction
//                scheduler. Holds the RV64 system-opcode macros used by the
//                upstream decoder that produces sys_v_i / sys_wfi_i, and the
//                scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef BP_BE_RV64_SYS_DEFINES
`define BP_BE_RV64_SYS_DEFINES
// RV64 opcodes/encodings the decoder classifies as serializing.
`define RV64_SYSTEM_OP    7'b1110011
`define RV64_MISC_MEM_OP  7'b0001111
`define RV64_FUNCT3_PRIV  3'b000
`define RV64_WFI_INSTR    32'h10500073
`define RV64_FENCE_I_F3   3'b001
`endif

package bp_be_pkg;

    // Scheduler sequencing states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        e_idle  = 3'd0,
        e_drain = 3'd1,
        e_issue = 3'd2,
        e_wait  = 3'd3,
        e_wfi   = 3'd4
    } bp_be_sys_sched_state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_counter_up_down.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_counter_up_down
//  Description : Up/down counter with multi-unit steps. The caller guarantees
//                the count never goes below zero or above max_val_p.
//  Ports       : clk_i, reset_i (sync, active-high, returns to init_val_p),
//                up_i / down_i (step amounts), count_o (current value).
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_counter_up_down #(
    parameter int max_val_p  = 8,
    parameter int init_val_p = 0,
    parameter int max_step_p = 2
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [$clog2(max_step_p+1)-1:0]   up_i,
    input  logic [$clog2(max_step_p+1)-1:0]   down_i,
    output logic [$clog2(max_val_p+1)-1:0]    count_o
);

    localparam int c_WIDTH      = $clog2(max_val_p+1);
    localparam int c_STEP_WIDTH = $clog2(max_step_p+1);

    logic [c_WIDTH-1:0] r_count;
    logic [c_WIDTH-1:0] w_up;
    logic [c_WIDTH-1:0] w_down;

    assign w_up   = {{(c_WIDTH-c_STEP_WIDTH){1'b0}}, up_i};
    assign w_down = {{(c_WIDTH-c_STEP_WIDTH){1'b0}}, down_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= c_WIDTH'(init_val_p);
        end else begin
            r_count <= r_count + w_up - w_down;
        end
    end

    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/bp_be_sys_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_sys_scheduler
//  Description : Serializes system instructions (CSR, fence, WFI) into the
//                system pipe. Counts in-flight instructions, gates ordinary
//                dispatch while a serializing instruction waits, issues it
//                once the backend drains, holds until it retires and parks
//                in WFI until an interrupt is pending.
//  Ports       : dispatch_v_i / dispatch_ready_and_o - ordinary dispatch
//                sys_v_i, sys_wfi_i / sys_ready_and_o - serializing head
//                sys_issue_v_o  - strobe to system pipe reservation
//                retire_v_i, flush_i, irq_pending_i - backend events
//                inflight_o, wfi_o, error_o (sticky underflow)
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_be_sys_scheduler
    import bp_be_pkg::*;
#(
    parameter int inflight_max_p    = 8,
    parameter int inflight_width_lp = $clog2(inflight_max_p+1)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          dispatch_v_i,
    output logic                          dispatch_ready_and_o,
    input  logic                          sys_v_i,
    input  logic                          sys_wfi_i,
    output logic                          sys_ready_and_o,
    output logic                          sys_issue_v_o,
    input  logic                          retire_v_i,
    input  logic                          flush_i,
    input  logic                          irq_pending_i,
    output logic [inflight_width_lp-1:0]  inflight_o,
    output logic                          wfi_o,
    output logic                          error_o
);

    bp_be_sys_sched_state_e        r_state;
    logic                          r_wfi;
    logic                          r_error;

    logic [inflight_width_lp-1:0]  w_count;
    logic                          w_count_zero;
    logic                          w_dispatch_fire;
    logic                          w_issue;
    logic                          w_retire_ok;
    logic                          w_underflow;
    logic                          w_cnt_reset;
    logic [1:0]                    w_up;
    logic [1:0]                    w_down;

    assign w_count_zero = (w_count == '0);

    assign dispatch_ready_and_o = (r_state == e_idle) & ~sys_v_i
                                & (w_count < inflight_width_lp'(inflight_max_p));

    assign w_dispatch_fire = dispatch_v_i & dispatch_ready_and_o;

    // Issue strobe is a decode of the registered state; a flush in the same
    // cycle kills it so the system pipe never sees a squashed instruction.
    assign w_issue         = (r_state == e_issue) & ~flush_i;
    assign sys_issue_v_o   = w_issue;
    assign sys_ready_and_o = w_issue;

    // Retires with nothing in flight are dropped (and flagged) rather than
    // letting the counter wrap. Flush discards all counter activity.
    assign w_retire_ok = retire_v_i & ~w_count_zero & ~flush_i;
    assign w_underflow = retire_v_i &  w_count_zero & ~flush_i;

    // Dispatch only fires in e_idle and issue only in e_issue, so up never
    // exceeds one in practice; the counter still accepts a 2-unit step.
    assign w_up   = {1'b0, w_dispatch_fire} + {1'b0, w_issue};
    assign w_down = {1'b0, w_retire_ok};

    assign w_cnt_reset = reset_i | flush_i;

    bsg_counter_up_down #(
        .max_val_p  (inflight_max_p),
        .init_val_p (0),
        .max_step_p (2)
    ) u_inflight_cnt (
        .clk_i   (clk_i),
        .reset_i (w_cnt_reset),
        .up_i    (w_up),
        .down_i  (w_down),
        .count_o (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_idle;
            r_wfi   <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_underflow) begin
                r_error <= 1'b1;
            end
            if (flush_i) begin
                r_state <= e_idle;
                r_wfi   <= 1'b0;
            end else begin
                case (r_state)
                    e_idle: begin
                        if (sys_v_i) begin
                            r_state <= w_count_zero ? e_issue : e_drain;
                        end
                    end
                    e_drain: begin
                        // Head squashed upstream takes priority over draining.
                        if (!sys_v_i) begin
                            r_state <= e_idle;
                        end else if (w_count_zero) begin
                            r_state <= e_issue;
                        end
                    end
                    e_issue: begin
                        r_wfi   <= sys_wfi_i;
                        r_state <= e_wait;
                    end
                    e_wait: begin
                        // Pipe was empty at issue, so the first retire seen
                        // here belongs to the serializing instruction.
                        if (retire_v_i) begin
                            r_state <= r_wfi ? e_wfi : e_idle;
                        end
                    end
                    e_wfi: begin
                        if (irq_pending_i) begin
                            r_state <= e_idle;
                            r_wfi   <= 1'b0;
                        end
                    end
                    default: r_state <= e_idle;
                endcase
            end
        end
    end

    assign inflight_o = w_count;
    assign wfi_o      = (r_state == e_wfi);
    assign error_o    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_bp_be_sys_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_be_sys_scheduler
//  Description : Self-checking bench for bp_be_sys_scheduler. A table of
//                per-cycle stimulus/expected records is driven in order;
//                expectations flow through a scoreboard queue and are
//                compared when the cycle's outputs settle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_be_sys_scheduler;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       dispatch_v_i;
    logic       dispatch_ready_and_o;
    logic       sys_v_i;
    logic       sys_wfi_i;
    logic       sys_ready_and_o;
    logic       sys_issue_v_o;
    logic       retire_v_i;
    logic       flush_i;
    logic       irq_pending_i;
    logic [3:0] inflight_o;
    logic       wfi_o;
    logic       error_o;

    always #5 clk_i = ~clk_i;

    bp_be_sys_scheduler #(.inflight_max_p(8)) dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .dispatch_v_i         (dispatch_v_i),
        .dispatch_ready_and_o (dispatch_ready_and_o),
        .sys_v_i              (sys_v_i),
        .sys_wfi_i            (sys_wfi_i),
        .sys_ready_and_o      (sys_ready_and_o),
        .sys_issue_v_o        (sys_issue_v_o),
        .retire_v_i           (retire_v_i),
        .flush_i              (flush_i),
        .irq_pending_i        (irq_pending_i),
        .inflight_o           (inflight_o),
        .wfi_o                (wfi_o),
        .error_o              (error_o)
    );

    typedef struct {
        logic       d, s, w, r, f, q;
        logic [3:0] inf;
        logic       dr, iss, wfi, err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic v(input logic d, s, w, r, f, q, input int inf,
                     input logic dr, iss, wf, err);
        vec_t t;
        t.d = d; t.s = s; t.w = w; t.r = r; t.f = f; t.q = q;
        t.inf = 4'(inf); t.dr = dr; t.iss = iss; t.wfi = wf; t.err = err;
        vecs.push_back(t);
    endtask

    task automatic drive_idle();
        dispatch_v_i = 0; sys_v_i = 0; sys_wfi_i = 0;
        retire_v_i = 0; flush_i = 0; irq_pending_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   pulses;

        //  d  s  w  r  f  q   inf dr iss wfi err
        // Three dispatches.
        v(0,0,0,0,0,0, 0, 1,0,0,0);
        v(1,0,0,0,0,0, 0, 1,0,0,0);
        v(1,0,0,0,0,0, 1, 1,0,0,0);
        v(1,0,0,0,0,0, 2, 1,0,0,0);
        // Serializing head with 3 in flight: drain, issue once, wait, retire.
        v(0,1,0,0,0,0, 3, 0,0,0,0);
        v(0,1,0,1,0,0, 3, 0,0,0,0);
        v(0,1,0,1,0,0, 2, 0,0,0,0);
        v(0,1,0,1,0,0, 1, 0,0,0,0);
        v(0,1,0,0,0,0, 0, 0,0,0,0);
        v(0,1,0,0,0,0, 0, 0,1,0,0);
        v(0,0,0,0,0,0, 1, 0,0,0,0);
        v(0,0,0,1,0,0, 1, 0,0,0,0);
        v(0,0,0,0,0,0, 0, 1,0,0,0);
        // WFI on an empty pipe.
        v(0,1,1,0,0,0, 0, 0,0,0,0);
        v(0,1,1,0,0,0, 0, 0,1,0,0);
        v(0,0,0,1,0,0, 1, 0,0,0,0);
        for (int k = 0; k < 10; k++) v(0,0,0,0,0,0, 0, 0,0,1,0);
        v(0,0,0,0,0,1, 0, 0,0,1,0);
        v(0,0,0,0,0,0, 0, 1,0,0,0);
        // Fill to the in-flight limit.
        for (int k = 0; k < 8; k++) v(1,0,0,0,0,0, k, 1,0,0,0);
        v(1,0,0,0,0,0, 8, 0,0,0,0);
        v(1,0,0,1,0,0, 8, 0,0,0,0);
        v(1,0,0,1,0,0, 7, 1,0,0,0);
        v(1,0,0,0,0,0, 7, 1,0,0,0);
        v(0,0,0,0,0,0, 8, 0,0,0,0);
        // Down to 5, drain, flush with a simultaneous retire.
        v(0,0,0,1,0,0, 8, 0,0,0,0);
        v(0,0,0,1,0,0, 7, 1,0,0,0);
        v(0,0,0,1,0,0, 6, 1,0,0,0);
        v(0,1,0,0,0,0, 5, 0,0,0,0);
        v(0,1,0,0,0,0, 5, 0,0,0,0);
        v(0,1,0,1,1,0, 5, 0,0,0,0);
        v(0,0,0,0,0,0, 0, 1,0,0,0);
        // Underflow: sticky error, count stays 0.
        v(0,0,0,1,0,0, 0, 1,0,0,0);
        v(0,0,0,0,0,0, 0, 1,0,0,1);
        v(0,0,0,1,0,0, 0, 1,0,0,1);
        v(0,0,0,0,0,0, 0, 1,0,0,1);
        // Head squashed while draining.
        v(1,0,0,0,0,0, 0, 1,0,0,1);
        v(0,1,0,0,0,0, 1, 0,0,0,1);
        v(0,0,0,0,0,0, 1, 0,0,0,1);
        v(0,0,0,1,0,0, 1, 1,0,0,1);
        v(0,0,0,0,0,0, 0, 1,0,0,1);
        // Flush in the issue cycle suppresses the strobe.
        v(0,1,0,0,0,0, 0, 0,0,0,1);
        v(0,1,0,0,1,0, 0, 0,0,0,1);
        v(0,0,0,0,0,0, 0, 1,0,0,1);

        drive_idle();
        reset_i = 1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_inflight", 32'(inflight_o), 0);
        chk("rst_error", 32'(error_o), 0);
        chk("rst_issue", 32'(sys_issue_v_o), 0);
        chk("rst_ready", 32'(sys_ready_and_o), 0);
        chk("rst_wfi", 32'(wfi_o), 0);
        chk("rst_dispatch_ready", 32'(dispatch_ready_and_o), 1);
        @(posedge clk_i); #1;
        reset_i = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk_i); #1;
            dispatch_v_i  = vecs[i].d;
            sys_v_i       = vecs[i].s;
            sys_wfi_i     = vecs[i].w;
            retire_v_i    = vecs[i].r;
            flush_i       = vecs[i].f;
            irq_pending_i = vecs[i].q;
            sb.push_back(vecs[i]);
            @(negedge clk_i);
            e = sb.pop_front();
            chk($sformatf("v%0d_inflight", i), 32'(inflight_o), 32'(e.inf));
            chk($sformatf("v%0d_dispatch_ready", i), 32'(dispatch_ready_and_o), 32'(e.dr));
            chk($sformatf("v%0d_issue", i), 32'(sys_issue_v_o), 32'(e.iss));
            chk($sformatf("v%0d_sys_ready", i), 32'(sys_ready_and_o), 32'(e.iss));
            chk($sformatf("v%0d_wfi", i), 32'(wfi_o), 32'(e.wfi));
            chk($sformatf("v%0d_error", i), 32'(error_o), 32'(e.err));
        end

        // Reset clears the sticky error.
        @(posedge clk_i); #1;
        drive_idle();
        reset_i = 1;
        @(posedge clk_i); #1;
        reset_i = 0;
        @(negedge clk_i);
        chk("hs_error_cleared", 32'(error_o), 0);

        // Drain of two, then count issue pulses within a bounded window.
        @(posedge clk_i); #1; dispatch_v_i = 1;
        @(posedge clk_i); #1; dispatch_v_i = 1;
        @(posedge clk_i); #1; dispatch_v_i = 0; sys_v_i = 1;
        @(posedge clk_i); #1; retire_v_i = 1;
        @(posedge clk_i); #1; retire_v_i = 1;
        @(posedge clk_i); #1; retire_v_i = 0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(posedge clk_i); #1;
            end
            if (pulses > 0) sys_v_i = 0;
            @(negedge clk_i);
            if (sys_issue_v_o) pulses++;
        end
        chk("hs_issue_pulses", 32'(pulses), 1);
        chk("hs_wait_inflight", 32'(inflight_o), 1);
        chk("hs_wait_dispatch_blocked", 32'(dispatch_ready_and_o), 0);
        @(posedge clk_i); #1; retire_v_i = 1;
        @(posedge clk_i); #1; retire_v_i = 0;
        @(negedge clk_i);
        chk("hs_done_inflight", 32'(inflight_o), 0);
        chk("hs_done_dispatch_ready", 32'(dispatch_ready_and_o), 1);
        chk("hs_done_error", 32'(error_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bp_be_sys_scheduler.md
# bp_be_sys_scheduler

Issue-side sequencer for serializing system instructions (CSR reads/writes, fences, WFI) bound for the system pipe. It tracks the number of in-flight instructions and blocks ordinary dispatch while a serializing instruction waits. It issues the serializing instruction only once the backend has drained, holds until that instruction retires, and parks the core in a WFI wait state until an interrupt is pending. It sits between the scheduler's issue head and the system pipe's reservation input.

## Interface
Parameters:
- inflight_max_p, 8: maximum number of instructions in flight between issue and retire.
- inflight_width_lp, derived: `$clog2(inflight_max_p+1)`.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- dispatch_v_i  in  1  a non-serializing instruction is presented for dispatch.
- dispatch_ready_and_o  out  1  non-serializing dispatch is permitted this cycle.
- sys_v_i  in  1  the issue head is a serializing system instruction.
- sys_wfi_i  in  1  the head instruction is WFI; qualified by sys_v_i.
- sys_ready_and_o  out  1  the serializing instruction is accepted this cycle.
- sys_issue_v_o  out  1  valid strobe to the system pipe reservation.
- retire_v_i  in  1  one instruction retires (any type).
- flush_i  in  1  backend flush.
- irq_pending_i  in  1  interrupt pending, from the CSR unit.
- inflight_o  out  inflight_width_lp  current in-flight count.
- wfi_o  out  1  the core is parked in WFI.
- error_o  out  1  sticky; set when a retire arrives with zero instructions in flight.

## Operation
- State machine states: e_idle, e_drain, e_issue, e_wait, e_wfi.
- e_idle:
  - sys_v_i with count==0 → e_issue.
  - sys_v_i with count>0 → e_drain.
- e_drain: → e_issue in the cycle after count reaches 0. Count is sampled registered.
- e_issue:
  - sys_issue_v_o=1 and sys_ready_and_o=1 for exactly one cycle.
  - Latch sys_wfi_i into wfi_r.
  - → e_wait.
- e_wait: on retire_v_i → e_wfi if wfi_r, else e_idle.
- e_wfi: wfi_o=1; on irq_pending_i → e_idle. An irq already pending on entry leaves after one cycle.
- Dispatch gating: dispatch_ready_and_o = (state==e_idle) & ~sys_v_i & (count<inflight_max_p).
- Counter, per cycle:
  - +1 for dispatch_v_i & dispatch_ready_and_o.
  - +1 for sys_issue_v_o.
  - −1 for retire_v_i.
  - Increment and decrement in the same cycle net to unchanged.
  - The count saturates at inflight_max_p only through dispatch gating; it never wraps.
- Underflow: retire_v_i with count==0 leaves the count at 0 and sets error_o. error_o is cleared only by reset.
- Flush:
  - flush_i in any state → e_idle, count forced to 0, wfi_r cleared.
  - Flush overrides a simultaneous retire, dispatch, or issue.
  - sys_issue_v_o is suppressed in the flush cycle.
- sys_v_i may drop while in e_drain (the instruction was squashed upstream): → e_idle.

## Timing
- Reset values: state e_idle, count 0, wfi_r 0, error_o 0, sys_issue_v_o 0, sys_ready_and_o 0, wfi_o 0, inflight_o 0. dispatch_ready_and_o=1 when sys_v_i=0.
- Outputs:
  - sys_issue_v_o, sys_ready_and_o and wfi_o decode from registered state only.
  - dispatch_ready_and_o is combinational from state, count and sys_v_i.
- Latency:
  - sys_v_i in e_idle with an empty pipe → issue 1 cycle later.
  - With N instructions in flight → issue 1 cycle after the retire that empties the pipe.
- Minimum serializing round trip is 3 cycles: idle → issue → wait → idle, with retire in the cycle after issue.
- A retire in the same cycle as e_issue decrements the count (for an older instruction) and does not count as the serializing instruction's retire.

## Structure
- Shared package (bp_be_pkg):
  - bp_be_sys_sched_state_e enum.
  - Include of the RV64 system-opcode macros used by the upstream decoder that drives sys_v_i and sys_wfi_i.
- Sub-module: bsg_counter_up_down (max_val_p=inflight_max_p, max_step_p=2). The error and clamp logic stays outside it.
- The FSM and gating logic stay in bp_be_sys_scheduler.

## Test plan
- Reset, then dispatch_v_i=1 for 3 cycles → inflight_o=3 and dispatch_ready_and_o=1 throughout.
- 3 in flight, sys_v_i=1 → dispatch_ready_and_o=0; after 3 retires, sys_issue_v_o pulses exactly once. One retire later → e_idle and inflight_o=0.
- WFI: sys_v_i=1, sys_wfi_i=1 on an empty pipe → issue, retire, then wfi_o=1 held for 10 cycles. irq_pending_i=1 → wfi_o=0 the next cycle.
- Fill to 8 in flight → dispatch_ready_and_o=0. A retire and a dispatch in the same cycle → count stays 7, then returns to 8.
- flush_i during e_drain with 5 in flight → e_idle and count 0 next cycle. A simultaneous retire is ignored, and error_o stays 0.
- retire_v_i with count 0 → error_o=1 and sticky; inflight_o stays 0.
